lsu_mem_responder: RTL

LSU_MEM_RESPONDER -- requirements
Module: lsu_mem_responder

---
 rtl/lsu_mem_responder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/lsu_mem_responder.sv
// Word-organised load/store responder: zero-wait writes in IDLE, fixed-latency
// reads through an IDLE/WAIT/RESP sequencer, byte-lane storage per 32-bit word.
module lsu_mem_responder #(
  parameter int          DEPTH        = 256,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_ren,
  input  logic        lsu_wen,
  input  logic [1:0]  lsu_type,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        busy
);

  localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [31:0] addr_q, addr_nx;
  logic [1:0]  type_q, type_nx;

  logic        wr_fire, wr_err, wr_ok, rd_err, in_resp;
  logic [31:0] wr_idx, rd_idx, rd_ext;
  logic [3:0]  lane_we;
  logic [3:0][7:0] lane_wdata, lane_rdata;

  function automatic logic [31:0] word_idx(input logic [31:0] a);
    return (a - BASE_ADDR) >> 2;
  endfunction

  function automatic logic acc_err(input logic [31:0] a, input logic [1:0] t);
    logic misal;
    case (t)
      2'b00:   misal = 1'b0;
      2'b01:   misal = a[0];
      default: misal = |a[1:0];
    endcase
    return (word_idx(a) >= 32'(DEPTH)) || misal;
  endfunction

  // Writes bypass the FSM entirely; rst_n gating keeps reset-time strobes inert.
  assign wr_fire = rst_n && (state == IDLE) && lsu_wen;
  assign wr_err  = acc_err(lsu_addr, lsu_type);
  assign wr_ok   = wr_fire && !wr_err;
  assign wr_idx  = word_idx(lsu_addr);
  assign rd_idx  = word_idx(addr_q);
  assign rd_err  = acc_err(addr_q, type_q);
  assign in_resp = (state == RESP);

  always_comb begin
    lane_we = '0;
    case (lsu_type)
      2'b00:   lane_we[lsu_addr[1:0]] = 1'b1;
      2'b01:   lane_we = lsu_addr[1] ? 4'b1100 : 4'b0011;
      default: lane_we = 4'b1111;
    endcase
    lane_we &= {4{wr_ok}};
  end

  // Replicating right-aligned data lets every enabled lane pick up its own byte.
  always_comb begin
    case (lsu_type)
      2'b00:   lane_wdata = {4{lsu_wdata[7:0]}};
      2'b01:   lane_wdata = {2{lsu_wdata[15:0]}};
      default: lane_wdata = lsu_wdata;
    endcase
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (lane_we[g]) mem[wr_idx[AW-1:0]] <= lane_wdata[g];
    end
    assign lane_rdata[g] = mem[rd_idx[AW-1:0]];
  end

  always_comb begin
    case (type_q)
      2'b00:   rd_ext = {24'b0, lane_rdata[addr_q[1:0]]};
      2'b01:   rd_ext = {16'b0, lane_rdata[{addr_q[1], 1'b1}], lane_rdata[{addr_q[1], 1'b0}]};
      default: rd_ext = lane_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      type_q <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      addr_q <= addr_nx;
      type_q <= type_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    addr_nx   = addr_q;
    type_nx   = type_q;
    case (state)
      IDLE: begin
        if (!lsu_wen && lsu_ren) begin
          addr_nx  = lsu_addr;
          type_nx  = lsu_type;
          cnt_nx   = LAT_M1;
          state_nx = (READ_LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt_nx == 4'd0) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    lsu_done  = wr_fire | in_resp;
    lsu_err   = (wr_fire & wr_err) | (in_resp & rd_err);
    lsu_rdata = (in_resp && !rd_err) ? rd_ext : '0;
    busy      = (state != IDLE);
  end

endmodule
